// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared opcodes, FSM state type and condition-code helpers
package lc3_pkg;

   localparam int REG_W = 3;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b1001;

   localparam logic [2:0] NZP_N = 3'b100;
   localparam logic [2:0] NZP_Z = 3'b010;
   localparam logic [2:0] NZP_P = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_OPERAND   = 2'd1,
      S_WRITEBACK = 2'd2
   } state_t;

   function automatic logic [15:0] sext5(input logic [4:0] imm);
      return {{11{imm[4]}}, imm};
   endfunction

   function automatic logic [2:0] nzp_of(input logic [15:0] value);
      if (value[15])
         return NZP_N;
      else if (value == 16'h0000)
         return NZP_Z;
      else
         return NZP_P;
   endfunction

   // NOT is only executable with its reserved low field all ones
   function automatic logic is_legal(input logic [15:0] word);
      case (word[15:12])
         OP_ADD, OP_AND: return 1'b1;
         OP_NOT:         return (word[5:0] == 6'b111111);
         default:        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lc3_regfile.sv
// rtl/lc3_regfile.sv - 8x16 register file, one write port, three async read ports
module lc3_regfile
   import lc3_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [REG_W-1:0] waddr,
   input  logic [15:0]      wdata,
   input  logic [REG_W-1:0] raddr1,
   input  logic [REG_W-1:0] raddr2,
   input  logic [REG_W-1:0] raddr3,
   output logic [15:0]      rdata1,
   output logic [15:0]      rdata2,
   output logic [15:0]      rdata3
);

   logic [15:0] mem [8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++)
            mem[i] <= 16'h0000;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata1 = mem[raddr1];
   assign rdata2 = mem[raddr2];
   assign rdata3 = mem[raddr3];

endmodule

// File: rtl/lc3_exec_ctrl.sv
// rtl/lc3_exec_ctrl.sv - three-state execute controller for LC-3 ADD/AND/NOT
// Latches one instruction, feeds an external ALU and writes its result back.
module lc3_exec_ctrl
   import lc3_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_valid,
   input  logic [15:0] inst,
   output logic        inst_ready,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [15:0] alu_out,
   output logic [2:0]  nzp,
   output logic        wb_valid,
   output logic [2:0]  wb_reg,
   output logic [15:0] wb_data,
   output logic        illegal,
   input  logic [2:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   state_t      state;
   logic [15:0] ir;
   logic [15:0] sr1_data;
   logic [15:0] sr2_data;

   lc3_regfile u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wb_valid),
      .waddr  (ir[11:9]),
      .wdata  (alu_out),
      .raddr1 (ir[8:6]),
      .raddr2 (ir[2:0]),
      .raddr3 (dbg_addr),
      .rdata1 (sr1_data),
      .rdata2 (sr2_data),
      .rdata3 (dbg_data)
   );

   assign wb_reg  = ir[11:9];
   assign wb_data = alu_out;

   always_comb begin
      alu_a  = 16'h0000;
      alu_b  = 16'h0000;
      alu_op = 4'b0000;
      if (state != S_IDLE) begin
         alu_a  = sr1_data;
         alu_op = ir[15:12];
         if (ir[15:12] != OP_NOT)
            alu_b = ir[5] ? sext5(ir[4:0]) : sr2_data;
      end
   end

   // Handshake and pulse outputs are registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ir         <= 16'h0000;
         inst_ready <= 1'b1;
         wb_valid   <= 1'b0;
         illegal    <= 1'b0;
         nzp        <= NZP_Z;
      end else begin
         illegal <= 1'b0;
         case (state)
            S_IDLE: begin
               if (inst_valid) begin
                  ir         <= inst;
                  state      <= S_OPERAND;
                  inst_ready <= 1'b0;
                  illegal    <= !is_legal(inst);
               end
            end
            S_OPERAND: begin
               if (is_legal(ir)) begin
                  state    <= S_WRITEBACK;
                  wb_valid <= 1'b1;
               end else begin
                  state      <= S_IDLE;
                  inst_ready <= 1'b1;
               end
            end
            S_WRITEBACK: begin
               nzp        <= nzp_of(alu_out);
               wb_valid   <= 1'b0;
               inst_ready <= 1'b1;
               state      <= S_IDLE;
            end
            default: begin
               state      <= S_IDLE;
               wb_valid   <= 1'b0;
               inst_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/lc3_exec_ctrl.md
LC3_EXEC_CTRL -- requirements
Module: lc3_exec_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 inst_valid  in  1  upstream instruction present.
REQ-004 inst  in  16  LC-3 instruction word.
REQ-005 inst_ready  out  1  block can accept; transfer on inst_valid & inst_ready at clk edge.
REQ-006 alu_a, alu_b  out  16 each  operands to the downstream ALU.
REQ-007 alu_op  out  4  opcode to the ALU (0001 ADD, 0101 AND, 1001 NOT).
REQ-008 alu_out  in  16  ALU combinational result.
REQ-009 nzp  out  3  condition codes {N,Z,P}.
REQ-010 wb_valid  out  1  register write this cycle; wb_reg out 3 (destination); wb_data out 16 (value written).
REQ-011 illegal  out  1  one-cycle pulse: accepted instruction not executable.
REQ-012 dbg_addr  in  3 / dbg_data  out  16  combinational register-file read port.

Function
REQ-013 Decode: opcode=inst[15:12], DR=inst[11:9], SR1=inst[8:6], imm flag=inst[5], SR2=inst[2:0], imm5=inst[4:0] sign-extended to 16 bits.
REQ-014 Register file: 8 x 16-bit, one write port, three read ports (SR1, SR2, dbg).
REQ-015 FSM states IDLE, OPERAND, WRITEBACK; IDLE->OPERAND on accept; OPERAND->WRITEBACK if legal, else ->IDLE; WRITEBACK->IDLE always.
REQ-016 inst_ready = 1 only in IDLE; instruction latched on accept edge.
REQ-017 In OPERAND and WRITEBACK: alu_a=R[SR1]; alu_b = imm ? sext(imm5) : R[SR2] for ADD/AND; alu_b=0 for NOT; alu_op = latched opcode.
REQ-018 In IDLE: alu_a=0, alu_b=0, alu_op=0000.
REQ-019 Legal set: ADD, AND (either mode), NOT with inst[5:0]=111111; everything else illegal.
REQ-020 Illegal: illegal=1 during the OPERAND cycle, no register write, nzp unchanged, return to IDLE (accept-to-ready 2 cycles).
REQ-021 WRITEBACK: wb_valid=1, wb_reg=DR, wb_data=alu_out; R[DR] and nzp updated at end of that cycle.
REQ-022 nzp update: 100 if bit15=1; 010 if value=0; 001 otherwise; always one-hot.
REQ-023 Latency: accept at edge 0, write at edge 2, inst_ready high in cycle 3; throughput one instruction per 3 cycles.
REQ-024 Read-after-write: next instruction reading the previous DR sees the new value (no bypass needed).
REQ-025 DR equal to SR1/SR2 allowed; operands are the pre-write values.
REQ-026 dbg_data reflects register contents after the most recent write edge.
REQ-027 inst_valid ignored outside IDLE; inst may change freely after accept.

Reset
REQ-028 rst_n low: FSM IDLE, all registers 0x0000, nzp=010, wb_valid=0, illegal=0, inst_ready=1 after release.
REQ-029 Reset mid-operation discards the in-flight instruction with no write or nzp change.

Structure
REQ-030 Shared package lc3_pkg: opcode constants OP_ADD/OP_AND/OP_NOT, FSM state type, NZP constants, register-index width.
REQ-031 Sub-module lc3_regfile (8x16, async reset, 2+1 read ports, 1 write port); ALU stays a separate instance outside this block.

Verification
REQ-032 Reset -> dbg_data=0x0000 for all 8 addresses, nzp=010, inst_ready=1.
REQ-033 0x1225 (ADD R1,R0,#5) with ALU model -> alu_b=0x0005; wb_valid at cycle 2, R1=0x0005, nzp=001.
REQ-034 Then 0x147A (ADD R2,R1,#-6) -> alu_a=0x0005, alu_b=0xFFFA, R2=0xFFFF, nzp=100.
REQ-035 Then 0x56A0 (AND R3,R2,#0) -> R3=0x0000, nzp=010; then 0x987F (NOT R4,R1) -> R4=0xFFFA, nzp=100.
REQ-036 0x0000 (BR) and 0x987E (malformed NOT) -> illegal pulse each, wb_valid never 1, nzp and all registers unchanged, inst_ready back after 2 cycles.
REQ-037 rst_n pulsed low in OPERAND of 0x1225 -> R1 stays 0x0000, nzp=010, no wb_valid, IDLE after release.
